cache_arbiter: RTL and testbench
================================

Name: cache_arbiter

Overview:
Two-port line-request arbiter between the instruction cache and the data cache, sitting directly upstream of the cacheline adaptor. It grants one cache at a time, forwards that cache's 256-bit line read or write to the adaptor, and returns the completed line and a one-cycle response to the granted cache. Round-robin on contention prevents starvation of either cache.

Parameters:
ADDR_W, 32, width of byte address on all ports
LINE_W, 256, cacheline width in bits
OFFSET_W, 5, line-offset bits; address bits [OFFSET_W-1:0] are forced to 0 downstream

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
i_mem_address  in  ADDR_W  icache line address
i_mem_read  in  1  icache line read request, level, held until i_mem_resp
i_mem_rdata  out  LINE_W  line returned to icache, valid when i_mem_resp=1
i_mem_resp  out  1  icache completion pulse, 1 cycle
d_mem_address  in  ADDR_W  dcache line address
d_mem_read  in  1  dcache line read request, level, held until d_mem_resp
d_mem_write  in  1  dcache line writeback request, level, held until d_mem_resp
d_mem_wdata  in  LINE_W  dcache writeback line, stable while request is held
d_mem_rdata  out  LINE_W  line returned to dcache, valid when d_mem_resp=1
d_mem_resp  out  1  dcache completion pulse, 1 cycle
a_mem_address  out  ADDR_W  line address to adaptor
a_mem_read  out  1  line read to adaptor
a_mem_write  out  1  line write to adaptor
a_mem_wdata  out  LINE_W  write line to adaptor
a_mem_rdata  in  LINE_W  line from adaptor, valid with a_mem_resp
a_mem_resp  in  1  adaptor completion pulse, 1 cycle

Behaviour:
- States: IDLE, SERVE_I, SERVE_D, RESP_I, RESP_D. Reset value: IDLE.
- Reset (any state, including mid-transfer): state=IDLE; all outputs 0; line register=0; last_served=I (so the first contested grant goes to D). An in-flight adaptor transfer is abandoned; the adaptor is reset in the same cycle.
- IDLE: no downstream strobes. req_i=i_mem_read; req_d=d_mem_read|d_mem_write.
  - Only req_i -> SERVE_I. Only req_d -> SERVE_D. Neither -> IDLE.
  - Both -> grant the port that is not last_served.
  - On grant, register address with bits [OFFSET_W-1:0]=0, op (read/write) and d_mem_wdata into hold registers; update last_served.
- SERVE_x: a_mem_address, a_mem_read/a_mem_write and a_mem_wdata are driven from the hold registers and stay constant until a_mem_resp. Exactly one of a_mem_read/a_mem_write is 1. Requester inputs are not re-sampled.
  - a_mem_resp=1 -> capture a_mem_rdata into the line register on reads; unchanged on writes; -> RESP_x.
  - Otherwise stay.
- RESP_x: x_mem_resp=1 for exactly this cycle; a_mem_read=a_mem_write=0; -> IDLE unconditionally. New requests are not sampled in RESP.
- i_mem_rdata and d_mem_rdata are both driven from the line register; only the matching resp qualifies them.
- Requester contract: drops its request in the cycle after its resp. IDLE therefore never re-grants a completed request.
- d_mem_read and d_mem_write both high is illegal; the block treats it as a write.
- Latency, uncontested: request visible in cycle 0 (IDLE) -> downstream strobe in cycle 1 -> a_mem_resp in cycle k -> x_mem_resp in cycle k+1. At most one transaction is outstanding; there is no queuing.
- a_mem_resp outside SERVE_x is ignored.

Test Plan:
- Reset: hold rst 2 cycles with both requests high -> all outputs 0; first grant after release goes to D (a_mem_write/read from d side).
- icache read: i_mem_address=0x0000_104C, adaptor resp 8 cycles later with rdata=0xA5..A5 -> a_mem_read=1 with a_mem_address=0x0000_1040 from cycle 1; i_mem_resp=1 one cycle after a_mem_resp; i_mem_rdata=0xA5..A5; d_mem_resp stays 0.
- dcache writeback: d_mem_write, address 0x8000_0020, wdata incrementing words -> a_mem_write=1 and a_mem_wdata matches until a_mem_resp; single d_mem_resp pulse; line register unchanged.
- Contention: both requests held continuously for 4 transactions -> grants alternate D, I, D, I; each requester gets exactly one resp per grant.
- Reset mid-transfer: assert rst while in SERVE_D before a_mem_resp -> next cycle a_mem_write=0 and d_mem_resp=0; a stray a_mem_resp afterwards produces no resp.
- Illegal op: d_mem_read=d_mem_write=1 -> a_mem_write=1, a_mem_read=0.

Source files
------------

// File: rtl/cache_arbiter_if.sv
// Line-request bundle between the two caches, the arbiter and the cacheline adaptor.
// slave is the arbiter's view; master is the view of everything around it.
interface cache_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    logic [ADDR_W-1:0] i_mem_address;
    logic              i_mem_read;
    logic [LINE_W-1:0] i_mem_rdata;
    logic              i_mem_resp;

    logic [ADDR_W-1:0] d_mem_address;
    logic              d_mem_read;
    logic              d_mem_write;
    logic [LINE_W-1:0] d_mem_wdata;
    logic [LINE_W-1:0] d_mem_rdata;
    logic              d_mem_resp;

    logic [ADDR_W-1:0] a_mem_address;
    logic              a_mem_read;
    logic              a_mem_write;
    logic [LINE_W-1:0] a_mem_wdata;
    logic [LINE_W-1:0] a_mem_rdata;
    logic              a_mem_resp;

    modport slave (
        input  i_mem_address, i_mem_read,
        output i_mem_rdata, i_mem_resp,
        input  d_mem_address, d_mem_read, d_mem_write, d_mem_wdata,
        output d_mem_rdata, d_mem_resp,
        output a_mem_address, a_mem_read, a_mem_write, a_mem_wdata,
        input  a_mem_rdata, a_mem_resp
    );

    modport master (
        output i_mem_address, i_mem_read,
        input  i_mem_rdata, i_mem_resp,
        output d_mem_address, d_mem_read, d_mem_write, d_mem_wdata,
        input  d_mem_rdata, d_mem_resp,
        input  a_mem_address, a_mem_read, a_mem_write, a_mem_wdata,
        output a_mem_rdata, a_mem_resp
    );
endinterface

// File: rtl/cache_arbiter.sv
// Round-robin arbiter granting the icache or dcache one line transfer at a time
// to the cacheline adaptor, returning the line and a one-cycle response.
module cache_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int LINE_W   = 256,
    parameter int OFFSET_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    cache_arbiter_if.slave        bus
);
    typedef enum logic [2:0] {
        IDLE,
        SERVE_I,
        SERVE_D,
        RESP_I,
        RESP_D
    } state_t;

    localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] hold_addr;
    logic              hold_write;
    logic [LINE_W-1:0] hold_wdata;
    logic [LINE_W-1:0] line_q;
    logic              last_d;
    logic              req_i;
    logic              req_d;
    logic              grant_i;
    logic              grant_d;
    logic              serving;
    logic              a_read;
    logic              a_write;
    logic              i_resp;
    logic              d_resp;

    assign req_i   = bus.i_mem_read;
    assign req_d   = bus.d_mem_read | bus.d_mem_write;
    assign serving = (state == SERVE_I) || (state == SERVE_D);

    always_comb begin
        next_state = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        a_read     = 1'b0;
        a_write    = 1'b0;
        i_resp     = 1'b0;
        d_resp     = 1'b0;
        case (state)
            IDLE: begin
                // On contention the port that was not served last wins
                if (req_i && req_d) begin
                    grant_d = !last_d;
                    grant_i = last_d;
                end else begin
                    grant_i = req_i;
                    grant_d = req_d;
                end
                if (grant_d) begin
                    next_state = SERVE_D;
                end else if (grant_i) begin
                    next_state = SERVE_I;
                end
            end
            SERVE_I, SERVE_D: begin
                a_read  = !hold_write;
                a_write = hold_write;
                if (bus.a_mem_resp) begin
                    if (state == SERVE_I) begin
                        next_state = RESP_I;
                    end else begin
                        next_state = RESP_D;
                    end
                end
            end
            RESP_I: begin
                i_resp     = 1'b1;
                next_state = IDLE;
            end
            RESP_D: begin
                d_resp     = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            hold_addr  <= '0;
            hold_write <= 1'b0;
            hold_wdata <= '0;
            line_q     <= '0;
            last_d     <= 1'b0;
        end else begin
            state <= next_state;
            // A simultaneous read and write from the dcache is treated as a write
            if (grant_i || grant_d) begin
                hold_addr  <= (grant_d ? bus.d_mem_address : bus.i_mem_address) & LINE_MASK;
                hold_write <= grant_d && bus.d_mem_write;
                hold_wdata <= bus.d_mem_wdata;
                last_d     <= grant_d;
            end
            if (serving && bus.a_mem_resp && !hold_write) begin
                line_q <= bus.a_mem_rdata;
            end
        end
    end

    assign bus.a_mem_address = serving ? hold_addr : '0;
    assign bus.a_mem_wdata   = serving ? hold_wdata : '0;
    assign bus.a_mem_read    = a_read;
    assign bus.a_mem_write   = a_write;
    assign bus.i_mem_resp    = i_resp;
    assign bus.d_mem_resp    = d_resp;
    assign bus.i_mem_rdata   = line_q;
    assign bus.d_mem_rdata   = line_q;
endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: directed scenarios with literal expectations, then
// randomized requesters and adaptor checked every cycle against a transaction model.
module tb_cache_arbiter;
    localparam int ADDR_W   = 32;
    localparam int LINE_W   = 256;
    localparam int OFFSET_W = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests_run    = 0;
    int   tests_failed = 0;

    cache_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

    cache_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .OFFSET_W(OFFSET_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [LINE_W-1:0] actual,
                               input logic [LINE_W-1:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [LINE_W-1:0] randLine();
        logic [LINE_W-1:0] v;
        for (int k = 0; k < LINE_W/32; k++) v[32*k +: 32] = $urandom;
        return v;
    endfunction

    // Transaction-level model: at most one outstanding transfer, then one response cycle
    bit                m_valid = 1'b0;
    bit                m_active;
    bit                m_write;
    bit                m_last_d;
    int                m_port;
    int                m_resp_port;
    logic [ADDR_W-1:0] m_addr;
    logic [LINE_W-1:0] m_wdata;
    logic [LINE_W-1:0] m_line;
    bit                want_i;
    bit                want_d;

    always @(negedge clk) begin
        if (m_valid) begin
            checkOutput("model a_mem_read", bus.a_mem_read, m_active && !m_write);
            checkOutput("model a_mem_write", bus.a_mem_write, m_active && m_write);
            if (m_active) begin
                checkOutput("model a_mem_address", bus.a_mem_address, m_addr);
                if (m_write) checkOutput("model a_mem_wdata", bus.a_mem_wdata, m_wdata);
            end
            checkOutput("model i_mem_resp", bus.i_mem_resp, m_resp_port == 0);
            checkOutput("model d_mem_resp", bus.d_mem_resp, m_resp_port == 1);
            checkOutput("model i_mem_rdata", bus.i_mem_rdata, m_line);
            checkOutput("model d_mem_rdata", bus.d_mem_rdata, m_line);
        end
        if (rst) begin
            m_valid     = 1'b1;
            m_active    = 1'b0;
            m_write     = 1'b0;
            m_resp_port = -1;
            m_line      = '0;
            m_last_d    = 1'b0;
        end else if (m_valid) begin
            if (m_resp_port >= 0) begin
                m_resp_port = -1;
            end else if (m_active) begin
                if (bus.a_mem_resp) begin
                    if (!m_write) m_line = bus.a_mem_rdata;
                    m_resp_port = m_port;
                    m_active    = 1'b0;
                end
            end else begin
                want_i = bus.i_mem_read;
                want_d = bus.d_mem_read || bus.d_mem_write;
                if (want_i || want_d) begin
                    if (want_i && want_d) m_port = m_last_d ? 0 : 1;
                    else                  m_port = want_d ? 1 : 0;
                    m_active = 1'b1;
                    m_addr   = (m_port == 1) ? bus.d_mem_address : bus.i_mem_address;
                    m_addr[OFFSET_W-1:0] = '0;
                    m_write  = (m_port == 1) && bus.d_mem_write;
                    m_wdata  = bus.d_mem_wdata;
                    m_last_d = (m_port == 1);
                end
            end
        end
    end

    bit ad_auto      = 1'b0;
    bit ad_busy      = 1'b0;
    int ad_count     = 0;
    int ad_fixed     = 3;
    bit stray_en     = 1'b0;
    bit rand_mode    = 1'b0;
    bit rand_quiet   = 1'b0;
    bit i_on         = 1'b0;
    bit d_on         = 1'b0;
    int op;

    task automatic applyStimulus();
        if (rst) begin
            rst = 1'b0;
        end else if (!rand_quiet && $urandom_range(99) == 0) begin
            rst = 1'b1;
            bus.i_mem_read  = 1'b0;
            bus.d_mem_read  = 1'b0;
            bus.d_mem_write = 1'b0;
            i_on = 1'b0;
            d_on = 1'b0;
        end else begin
            if (i_on) begin
                if (bus.i_mem_resp) begin
                    bus.i_mem_read = 1'b0;
                    i_on = 1'b0;
                end
            end else if (!rand_quiet && $urandom_range(2) == 0) begin
                bus.i_mem_address = $urandom;
                bus.i_mem_read    = 1'b1;
                i_on = 1'b1;
            end
            if (d_on) begin
                if (bus.d_mem_resp) begin
                    bus.d_mem_read  = 1'b0;
                    bus.d_mem_write = 1'b0;
                    d_on = 1'b0;
                end
            end else if (!rand_quiet && $urandom_range(2) == 0) begin
                op = $urandom_range(7);
                bus.d_mem_address = $urandom;
                bus.d_mem_wdata   = randLine();
                bus.d_mem_read    = (op < 4) || (op == 7);
                bus.d_mem_write   = (op >= 4);
                d_on = 1'b1;
            end
        end
    endtask

    // One clock: adaptor reacts to the strobes just produced, then the requesters
    task automatic step();
        @(posedge clk);
        #2;
        if (ad_auto) begin
            bus.a_mem_resp = 1'b0;
            if (rst) begin
                ad_busy = 1'b0;
            end else if (ad_busy) begin
                if (!(bus.a_mem_read || bus.a_mem_write)) begin
                    ad_busy = 1'b0;
                end else begin
                    ad_count--;
                    if (ad_count == 0) begin
                        bus.a_mem_resp  = 1'b1;
                        bus.a_mem_rdata = randLine();
                        ad_busy = 1'b0;
                    end
                end
            end else if (bus.a_mem_read || bus.a_mem_write) begin
                ad_busy  = 1'b1;
                ad_count = (ad_fixed > 0) ? ad_fixed : $urandom_range(1, 6);
            end else if (stray_en && $urandom_range(7) == 0) begin
                bus.a_mem_resp  = 1'b1;
                bus.a_mem_rdata = randLine();
            end
        end
        if (rand_mode) applyStimulus();
    endtask

    logic [LINE_W-1:0] wline;
    logic [3:0]        grant_was_d;
    int                grants;
    int                i_resps;
    int                d_resps;
    int                resp_count;
    int                write_cycles;
    bit                strobe;
    bit                prev_strobe;
    bit                i_reraise;
    bit                d_reraise;

    initial begin
        bus.i_mem_address = 32'h0000_2004;
        bus.i_mem_read    = 1'b1;
        bus.d_mem_address = 32'h0000_3010;
        bus.d_mem_read    = 1'b0;
        bus.d_mem_write   = 1'b1;
        bus.d_mem_wdata   = {8{32'h1234_5678}};
        bus.a_mem_rdata   = '0;
        bus.a_mem_resp    = 1'b0;

        for (int c = 0; c < 2; c++) begin
            step();
            checkOutput("reset a_mem_read", bus.a_mem_read, 1'b0);
            checkOutput("reset a_mem_write", bus.a_mem_write, 1'b0);
            checkOutput("reset a_mem_address", bus.a_mem_address, '0);
            checkOutput("reset i_mem_resp", bus.i_mem_resp, 1'b0);
            checkOutput("reset d_mem_resp", bus.d_mem_resp, 1'b0);
            checkOutput("reset i_mem_rdata", bus.i_mem_rdata, '0);
        end

        // Both caches keep asking; grants must alternate starting with the dcache
        rst = 1'b0;
        ad_auto = 1'b1;
        ad_fixed = 3;
        grants = 0; i_resps = 0; d_resps = 0; prev_strobe = 1'b0;
        i_reraise = 1'b0; d_reraise = 1'b0; grant_was_d = '0;
        for (int c = 0; c < 200 && (i_resps + d_resps) < 4; c++) begin
            step();
            strobe = bus.a_mem_read || bus.a_mem_write;
            if (strobe && !prev_strobe && grants < 4) begin
                grant_was_d[grants] = bus.a_mem_write;
                grants++;
            end
            prev_strobe = strobe;
            if (bus.i_mem_resp) begin
                i_resps++;
                bus.i_mem_read = 1'b0;
                i_reraise = (i_resps < 2);
            end else if (i_reraise) begin
                bus.i_mem_read = 1'b1;
                i_reraise = 1'b0;
            end
            if (bus.d_mem_resp) begin
                d_resps++;
                bus.d_mem_write = 1'b0;
                d_reraise = (d_resps < 2);
            end else if (d_reraise) begin
                bus.d_mem_write = 1'b1;
                d_reraise = 1'b0;
            end
        end
        checkOutput("contention grant count", grants, 4);
        checkOutput("contention grant order", grant_was_d, 4'b0101);
        checkOutput("contention icache resps", i_resps, 2);
        checkOutput("contention dcache resps", d_resps, 2);
        step();
        step();

        // icache read with the adaptor answering in cycle 8
        ad_auto = 1'b0;
        bus.i_mem_address = 32'h0000_104C;
        bus.i_mem_read    = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            step();
            checkOutput("icache a_mem_read", bus.a_mem_read, 1'b1);
            checkOutput("icache a_mem_write", bus.a_mem_write, 1'b0);
            checkOutput("icache a_mem_address", bus.a_mem_address, 32'h0000_1040);
        end
        bus.a_mem_rdata = {8{32'hA5A5_A5A5}};
        bus.a_mem_resp  = 1'b1;
        step();
        bus.a_mem_resp  = 1'b0;
        checkOutput("icache i_mem_resp", bus.i_mem_resp, 1'b1);
        checkOutput("icache i_mem_rdata", bus.i_mem_rdata, {8{32'hA5A5_A5A5}});
        checkOutput("icache d_mem_resp", bus.d_mem_resp, 1'b0);
        checkOutput("icache strobe dropped", bus.a_mem_read, 1'b0);
        bus.i_mem_read = 1'b0;
        step();
        checkOutput("icache resp width", bus.i_mem_resp, 1'b0);

        // dcache writeback of incrementing words
        ad_auto = 1'b1;
        ad_fixed = 4;
        for (int k = 0; k < LINE_W/32; k++) wline[32*k +: 32] = 32'(k + 1);
        bus.d_mem_address = 32'h8000_0020;
        bus.d_mem_wdata   = wline;
        bus.d_mem_read    = 1'b0;
        bus.d_mem_write   = 1'b1;
        resp_count = 0; write_cycles = 0;
        for (int c = 0; c < 16; c++) begin
            step();
            if (bus.a_mem_write) begin
                write_cycles++;
                checkOutput("dcache a_mem_wdata", bus.a_mem_wdata, wline);
                checkOutput("dcache a_mem_address", bus.a_mem_address, 32'h8000_0020);
                checkOutput("dcache a_mem_read", bus.a_mem_read, 1'b0);
            end
            if (bus.d_mem_resp) begin
                resp_count++;
                bus.d_mem_write = 1'b0;
                checkOutput("dcache line unchanged", bus.d_mem_rdata, {8{32'hA5A5_A5A5}});
            end
        end
        checkOutput("dcache resp count", resp_count, 1);
        checkOutput("dcache write strobe cycles", write_cycles, 5);

        // Reset while the dcache writeback waits on the adaptor
        ad_auto = 1'b0;
        bus.d_mem_address = 32'h0000_0440;
        bus.d_mem_wdata   = randLine();
        bus.d_mem_write   = 1'b1;
        step();
        step();
        checkOutput("midreset write before reset", bus.a_mem_write, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.d_mem_write = 1'b0;
        checkOutput("midreset a_mem_write", bus.a_mem_write, 1'b0);
        checkOutput("midreset d_mem_resp", bus.d_mem_resp, 1'b0);
        checkOutput("midreset line cleared", bus.d_mem_rdata, '0);
        bus.a_mem_rdata = randLine();
        bus.a_mem_resp  = 1'b1;
        step();
        bus.a_mem_resp  = 1'b0;
        resp_count = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (bus.i_mem_resp || bus.d_mem_resp) resp_count++;
        end
        checkOutput("midreset stray resp", resp_count, 0);

        // Read and write together from the dcache behaves as a write
        ad_auto = 1'b1;
        ad_fixed = 2;
        bus.d_mem_address = 32'h0000_0C08;
        bus.d_mem_read    = 1'b1;
        bus.d_mem_write   = 1'b1;
        step();
        checkOutput("illegal a_mem_write", bus.a_mem_write, 1'b1);
        checkOutput("illegal a_mem_read", bus.a_mem_read, 1'b0);
        checkOutput("illegal a_mem_address", bus.a_mem_address, 32'h0000_0C00);
        resp_count = 0;
        for (int c = 0; c < 20 && resp_count == 0; c++) begin
            step();
            if (bus.d_mem_resp) begin
                resp_count++;
                bus.d_mem_read  = 1'b0;
                bus.d_mem_write = 1'b0;
            end
        end
        checkOutput("illegal d_mem_resp seen", resp_count, 1);
        step();

        // Random traffic, random adaptor latency, stray responses and resets
        ad_fixed  = 0;
        stray_en  = 1'b1;
        rand_mode = 1'b1;
        for (int c = 0; c < 3000; c++) step();
        rand_quiet = 1'b1;
        for (int c = 0; c < 40; c++) step();
        checkOutput("drain a_mem_read", bus.a_mem_read, 1'b0);
        checkOutput("drain a_mem_write", bus.a_mem_write, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
